multi_timer_gen: RTL and testbench

//   N-channel programmable timer / clock generator. Successor to the single-channel

---
 rtl/multi_timer_gen_if.sv | 21 ++
 rtl/multi_timer_gen.sv | 75 +++++++
 tb/tb_multi_timer_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_gen_if.sv
// multi_timer_gen_if: register-side bundle for the multi-channel timer; TIMER_CAPTURE_EN adds cap/cap_val
interface multi_timer_gen_if #(parameter int N_CH = 4, parameter int CNT_W = 32, parameter int PRESC_W = 8);
    logic [PRESC_W-1:0]    presc;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       periodic;
    logic [N_CH-1:0]       clr;
    logic [N_CH*CNT_W-1:0] limit;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       done;
`ifdef TIMER_CAPTURE_EN
    logic [N_CH-1:0]       cap;
    logic [N_CH*CNT_W-1:0] cap_val;
    modport master (output presc, en, periodic, clr, limit, cap, input count, clk_out, tick, done, cap_val);
    modport slave (input presc, en, periodic, clr, limit, cap, output count, clk_out, tick, done, cap_val);
`else
    modport master (output presc, en, periodic, clr, limit, input count, clk_out, tick, done);
    modport slave (input presc, en, periodic, clr, limit, output count, clk_out, tick, done);
`endif
endinterface

// File: rtl/multi_timer_gen.sv
// multi_timer_gen: shared prescaler driving N periodic/one-shot channel counters; TIMER_CAPTURE_EN adds count capture
module multi_timer_gen #(parameter int N_CH = 4, parameter int CNT_W = 32, parameter int PRESC_W = 8) (
    input logic clk,
    input logic rst,
    multi_timer_gen_if.slave bus
);
    logic [PRESC_W-1:0] p;
    logic               ptick;
    logic [CNT_W-1:0]   cnt [N_CH];
    logic [N_CH-1:0]    co, tk, dn, stp, wrap;
    assign ptick = (|bus.en) && (p == bus.presc);
    assign stp = {N_CH{ptick}} & bus.en & ~dn;
    // terminal-count detect; >= lets a lowered limit wrap on the next step
    always_comb begin
        wrap = '0;
        for (int i = 0; i < N_CH; i++) wrap[i] = cnt[i] >= bus.limit[i*CNT_W +: CNT_W];
    end
    // shared prescaler, parked at 0 while no channel is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p <= '0;
        else p <= (!(|bus.en) || ptick) ? '0 : p + 1'b1;
    end
    // per-channel counter, divided clock, tick and sticky done; clr beats a step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            co <= '0;
            tk <= '0;
            dn <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.clr[i]) begin
                    cnt[i] <= '0;
                    co[i] <= 1'b0;
                    tk[i] <= 1'b0;
                    dn[i] <= 1'b0;
                end else begin
                    tk[i] <= stp[i] && wrap[i];
                    if (stp[i]) begin
                        cnt[i] <= wrap[i] ? '0 : cnt[i] + 1'b1;
                        co[i] <= co[i] ^ wrap[i];
                        dn[i] <= wrap[i] && !bus.periodic[i];
                    end
                end
            end
        end
    end
    assign bus.clk_out = co;
    assign bus.tick = tk;
    assign bus.done = dn;
    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign bus.count[g*CNT_W +: CNT_W] = cnt[g];
    end
`ifdef TIMER_CAPTURE_EN
    logic [N_CH-1:0]  s1, s2, s3;
    logic [CNT_W-1:0] cv [N_CH];
    // two-flop synchroniser plus edge flop; a rising edge latches the live count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            for (int i = 0; i < N_CH; i++) cv[i] <= '0;
        end else begin
            s1 <= bus.cap;
            s2 <= s1;
            s3 <= s2;
            for (int i = 0; i < N_CH; i++) cv[i] <= (s2[i] && !s3[i]) ? cnt[i] : cv[i];
        end
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_cap
        assign bus.cap_val[g*CNT_W +: CNT_W] = cv[g];
    end
`endif
endmodule

// File: tb/tb_multi_timer_gen.sv
// tb_multi_timer_gen: directed scoreboard bench for multi_timer_gen
module tb_multi_timer_gen;
    typedef struct {
        int          cyc;
        int          ch;
        logic        k;
        logic [31:0] cnt;
        logic        t, co, d;
        string       nm;
    } exp_t;

    logic clk, rst;
    int   cyc, compared, mismatched;
    exp_t q[$];
    exp_t e;
    logic [34:0] got, want;

    multi_timer_gen_if bus ();
    multi_timer_gen dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void ex(int c, int ch, logic [31:0] cnt, logic t, logic co, logic d, string nm);
        q.push_back('{c, ch, 1'b0, cnt, t, co, d, nm});
    endfunction

    function automatic void excap(int c, int ch, logic [31:0] v, string nm);
        q.push_back('{c, ch, 1'b1, v, 1'b0, 1'b0, 1'b0, nm});
    endfunction

    task automatic nxt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            want = {e.cnt, e.t, e.co, e.d};
            got = {bus.count[e.ch*32 +: 32], bus.tick[e.ch], bus.clk_out[e.ch], bus.done[e.ch]};
`ifdef TIMER_CAPTURE_EN
            if (e.k) got = {bus.cap_val[e.ch*32 +: 32], 3'b000};
`endif
            compared++;
            if (e.cyc != cyc || got != want) begin
                mismatched++;
                $display("FAIL %s cyc=%0d ch=%0d got cnt=%0d t=%b co=%b d=%b want cnt=%0d t=%b co=%b d=%b",
                         e.nm, cyc, e.ch, got[34:3], got[2], got[1], got[0], want[34:3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        int b;
        cyc = 0;
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.presc = '0;
        bus.en = '0;
        bus.periodic = '0;
        bus.clr = '0;
        bus.limit = '0;
`ifdef TIMER_CAPTURE_EN
        bus.cap = '0;
`endif
        nxt(1);
        for (int c = 0; c < 4; c++) ex(cyc, c, 0, 0, 0, 0, "reset_state");
        nxt(1);
        rst = 1'b0;
        nxt(1);
        // periodic limit 3, presc 0
        b = cyc;
        bus.limit[0 +: 32] = 32'd3;
        bus.periodic[0] = 1'b1;
        bus.en[0] = 1'b1;
        for (int k = 1; k <= 12; k++) ex(b + k, 0, 32'(k % 4), (k % 4) == 0, 1'((k / 4) % 2), 0, "t1_periodic");
        nxt(12);
        // lowered limit wraps on the next step
        b = cyc;
        bus.clr[0] = 1'b1;
        bus.limit[0 +: 32] = 32'd10;
        ex(b + 1, 0, 0, 0, 0, 0, "t3_clr");
        nxt(1);
        bus.clr[0] = 1'b0;
        ex(b + 8, 0, 7, 0, 0, 0, "t3_at7");
        nxt(7);
        bus.limit[0 +: 32] = 32'd5;
        ex(b + 9, 0, 0, 1, 1, 0, "t3_wrap");
        ex(b + 10, 0, 1, 0, 1, 0, "t3_after");
        ex(b + 14, 0, 5, 0, 1, 0, "t3_at5");
        ex(b + 15, 0, 0, 1, 0, 0, "t3_period6");
        nxt(9);
        // enable drop holds, resume continues
        bus.en[0] = 1'b0;
        ex(b + 18, 0, 2, 0, 0, 0, "hold_first");
        ex(b + 20, 0, 2, 0, 0, 0, "hold_last");
        nxt(3);
        bus.en[0] = 1'b1;
        ex(b + 21, 0, 3, 0, 0, 0, "resume");
        nxt(1);
        bus.en[0] = 1'b0;
        bus.clr[0] = 1'b1;
        nxt(1);
        bus.clr[0] = 1'b0;
        // one-shot, presc 4, limit 1
        b = cyc;
        bus.presc = 8'd4;
        bus.limit[32 +: 32] = 32'd1;
        bus.periodic[1] = 1'b0;
        bus.en[1] = 1'b1;
        ex(b + 5, 1, 1, 0, 0, 0, "t2_step1");
        ex(b + 9, 1, 1, 0, 0, 0, "t2_wait");
        ex(b + 10, 1, 0, 1, 1, 1, "t2_oneshot");
        ex(b + 11, 1, 0, 0, 1, 1, "t2_tick_end");
        ex(b + 16, 1, 0, 0, 1, 1, "t2_halt");
        nxt(16);
        bus.clr[1] = 1'b1;
        ex(b + 17, 1, 0, 0, 0, 0, "t2_clr");
        nxt(1);
        bus.clr[1] = 1'b0;
        ex(b + 20, 1, 1, 0, 0, 0, "t2_restart");
        ex(b + 25, 1, 0, 1, 1, 1, "t2_oneshot2");
        nxt(9);
        bus.en[1] = 1'b0;
        bus.clr[1] = 1'b1;
        bus.presc = 8'd0;
        nxt(1);
        bus.clr[1] = 1'b0;
        // clr beats a wrapping step
        b = cyc;
        bus.limit[64 +: 32] = 32'd9;
        bus.periodic[2] = 1'b1;
        bus.en[2] = 1'b1;
        ex(b + 9, 2, 9, 0, 0, 0, "t4_at9");
        nxt(9);
        bus.clr[2] = 1'b1;
        ex(b + 10, 2, 0, 0, 0, 0, "t4_clr_prio");
        nxt(1);
        bus.clr[2] = 1'b0;
        ex(b + 11, 2, 1, 0, 0, 0, "t4_restart");
        nxt(1);
        bus.en[2] = 1'b0;
        // async reset mid-count
        b = cyc;
        bus.limit[0 +: 32] = 32'd2;
        bus.periodic[0] = 1'b1;
        bus.en[0] = 1'b1;
        ex(b + 4, 0, 1, 0, 1, 0, "t5_pre");
        nxt(5);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) ex(b + 5, c, 0, 0, 0, 0, "t5_async_rst");
        nxt(1);
        rst = 1'b0;
        ex(b + 7, 0, 1, 0, 0, 0, "t5_restart");
        nxt(1);
        bus.en[0] = 1'b0;
`ifdef TIMER_CAPTURE_EN
        // capture three clocks after the async edge
        nxt(1);
        b = cyc;
        bus.limit[96 +: 32] = 32'd100;
        bus.periodic[3] = 1'b1;
        bus.en[3] = 1'b1;
        ex(b + 10, 3, 10, 0, 0, 0, "t6_at10");
        nxt(10);
        bus.cap[3] = 1'b1;
        excap(b + 12, 3, 0, "t6_cap_before");
        excap(b + 13, 3, 12, "t6_cap");
        nxt(4);
        bus.en[3] = 1'b0;
        bus.cap[3] = 1'b0;
`endif
        nxt(2);
        for (int i = 0; i < 100 && q.size() > 0; i++) nxt(1);
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
